axi_wb_writer: RTL and testbench
================================

# axi_wb_writer

Write-back buffer and AXI4 write-burst master for the L1 data cache. Accepts evicted dirty lines from the cache and queues them in a small FIFO. Drains each line as one INCR burst on the write channels of an `AxiIO.master` port. Provides a combinational address-hit check so that refills cannot overtake a pending write-back.

## Interface
Parameters:
- `DEPTH`, 2: number of line entries in the FIFO; must be a power of 2 and ≥2.
- `LINE_BEATS`, 8: `XLEN`-wide beats per line; must be a power of 2 and ≥2.
- `WB_ID`, 4'h1: AXI ID driven on AW.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-low reset.
- `req_valid`, input, 1: an evicted line is offered.
- `req_ready`, output, 1: the FIFO is not full.
- `req_addr`, input, `PADDR_BUS`: line address; low offset bits are ignored and forced to 0.
- `req_data`, input, `LINE_BEATS*XLEN`: line data; beat 0 is in the LSBs.
- `query_addr`, input, `PADDR_BUS`: line address to check for a hit.
- `query_hit`, output, 1: some valid entry matches `query_addr`.
- `wb_err`, output, 1: one-cycle pulse when a B response is not OKAY.
- `axi`, `AxiIO.master`: the AW, W and B channels are used. `mar.valid` and `mr.ready` are tied to 0, and all other read-channel fields are tied to 0.

## Operation
- FIFO:
  - Push on `req_valid && req_ready`.
  - The head entry is retained until its B handshake completes, then popped.
  - `req_ready` depends on occupancy only. There is no bypass when full, even if a pop happens in the same cycle.
- Line addresses are compared on bits [PADDR-1 : log2(LINE_BEATS*XLEN/8)].
  - `query_hit` ORs the matches over all valid entries, including the head while it is in flight.
  - `query_hit` reflects register state at the start of the cycle, so a same-cycle push is not visible.
- FSM states: IDLE, AW, W, B.
  - IDLE → AW when the FIFO is non-empty.
  - AW → W on `maw.valid && saw.ready`.
  - W → B on the handshake of the last beat.
  - B → IDLE on `sb.valid && mb.ready`. This pops the head.
- AW fields:
  - `id`=`WB_ID`, `addr`=aligned line address, `len`=`LINE_BEATS`-1.
  - `size`=log2(`XLEN`/8), `burst`=2'b01 (INCR), `cache`=4'b0011.
  - `lock`, `prot`, `qos`, `region`, `user` are 0.
- W channel:
  - A beat counter of log2(`LINE_BEATS`) bits selects the data slice.
  - `wstrb` is all ones, `user` is 0.
  - `last` is set exactly on beat `LINE_BEATS`-1.
- B channel:
  - `mb.ready`=1 only in state B.
  - Any `resp`≠2'b00 pulses `wb_err` in the handshake cycle. The entry is still popped; no retry.
- Valid stability: AW and W valid/payload stay constant until their handshake.
- Reset mid-burst: the FIFO is emptied, the FSM goes to IDLE, and the counter clears. The abandoned AXI transaction is covered by the global reset.

## Timing
- Reset values:
  - `req_ready`=1, `query_hit`=0 (no valid entries), `wb_err`=0.
  - `maw.valid`=0, `mw.valid`=0, `mb.ready`=0.
  - All other AXI outputs are 0.
- Push in cycle N:
  - The entry is visible to `query_hit` in cycle N+1.
  - If the FSM was idle and the FIFO empty, the FSM leaves IDLE in N+1 and `maw.valid` asserts in N+2.
- W beats (default build) start the cycle after the AW handshake, one beat per cycle when `sw.ready`=1.
- Zero-wait slave: 1 AW cycle + `LINE_BEATS` W cycles + ≥1 B cycle per line. The next line's AW asserts in the cycle after entering IDLE.
- With `DEPTH` full, `req_ready` rises in the cycle after the pop.

## Configuration
- `AXI_WB_AW_W_PARALLEL_EN`:
  - When defined, the AW and W states merge into AWW.
  - In AWW, `maw.valid` and `mw.valid` assert together, and two independent done flags (`aw_done`, `w_done`) are tracked.
  - AWW → B once both are done, in either order.
  - This saves one cycle per line on a zero-wait slave.
- When undefined, the FSM is strictly AW then W, as above.

## Test plan
- Single line, zero-wait slave, push addr 0x8000_0044 → AW addr=0x8000_0040, len=7, burst=INCR; 8 W beats with `last` only on beat 7; the entry pops after B.
- Fill: push 3 lines with `DEPTH`=2 while holding `saw.ready`=0 → `req_ready`=0 after the 2nd push; the 3rd line is accepted the cycle after the first B pop.
- Back-pressure: toggle `sw.ready` in a 1,0,0,1 pattern → data/`last` stay stable while stalled; beats arrive in order with no duplicates.
- Hazard: query line 0x8000_0040 while that line is in state W → `query_hit`=1; it drops to 0 the cycle after the B handshake.
- Error: B `resp`=2'b10 → `wb_err` high for exactly 1 cycle; the FIFO pops; the next line proceeds.
- Reset asserted mid-W (beat 3) → the next cycle shows all valids 0 and `req_ready`=1; with the macro enabled, repeat single-line and check AW and W1 appear in the same cycle.

Source files
------------

// File: rtl/axi_wb_writer_if.sv
// axi_wb_writer_if: shared bus widths, AXI4 channel payloads and the AxiIO bundle
package axi_wb_pkg;
  localparam int XLEN = 64;
  localparam int PADDR = 32;
  localparam int PADDR_BUS = 32;
  localparam int IDW = 4;
  typedef struct packed {
    logic valid;
    logic [IDW-1:0] id;
    logic [PADDR_BUS-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic user;
  } ax_t;
  typedef struct packed {
    logic ready;
  } rdy_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] data;
    logic [XLEN/8-1:0] strb;
    logic last;
    logic user;
  } w_t;
  typedef struct packed {
    logic valid;
    logic [IDW-1:0] id;
    logic [1:0] resp;
    logic user;
  } b_t;
  typedef struct packed {
    logic valid;
    logic [IDW-1:0] id;
    logic [XLEN-1:0] data;
    logic [1:0] resp;
    logic last;
    logic user;
  } r_t;
endpackage

interface AxiIO;
  import axi_wb_pkg::*;
  ax_t maw;
  rdy_t saw;
  w_t mw;
  rdy_t sw;
  b_t sb;
  rdy_t mb;
  ax_t mar;
  rdy_t sar;
  r_t sr;
  rdy_t mr;
  modport master(output maw, mw, mb, mar, mr, input saw, sw, sb, sar, sr);
  modport slave(input maw, mw, mb, mar, mr, output saw, sw, sb, sar, sr);
endinterface

// File: rtl/axi_wb_writer.sv
// axi_wb_writer: dirty-line write-back FIFO draining each line as one AXI4 INCR burst.
// Define AXI_WB_AW_W_PARALLEL_EN to issue AW and W concurrently (one state, two done flags).
module axi_wb_writer
  import axi_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LINE_BEATS = 8,
  parameter logic [IDW-1:0] WB_ID = 4'h1
) (
  input logic clk,
  input logic rst,
  input logic req_valid,
  output logic req_ready,
  input logic [PADDR_BUS-1:0] req_addr,
  input logic [LINE_BEATS*XLEN-1:0] req_data,
  input logic [PADDR_BUS-1:0] query_addr,
  output logic query_hit,
  output logic wb_err,
  AxiIO.master axi
);
  localparam int LW = LINE_BEATS * XLEN;
  localparam int OFF = $clog2(LW / 8);
  localparam int TW = PADDR - OFF;
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(LINE_BEATS);
  logic [TW-1:0] tag_q [DEPTH];
  logic [LW-1:0] line_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [1:0] state;
  logic [BW-1:0] beat;
  logic aw_valid, w_valid, push, pop, aw_hs, w_hs, w_end;
  logic unused;
  assign unused = ^{axi.sar, axi.sr, axi.sb.id, axi.sb.user, req_addr, query_addr};
  assign req_ready = count != (PW+1)'(DEPTH);
  assign push = req_valid && req_ready;
  assign pop = axi.mb.ready && axi.sb.valid;
  assign aw_hs = aw_valid && axi.saw.ready;
  assign w_hs = w_valid && axi.sw.ready;
  assign w_end = w_hs && axi.mw.last;
  assign wb_err = pop && axi.sb.resp != 2'b00;
  // Hazard check: any occupied slot, including the in-flight head, holding the queried line
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      query_hit = query_hit | (vld[i] && tag_q[i] == query_addr[PADDR-1:OFF]);
  end
  // Occupancy and pointers; the head slot is freed only by its B handshake
  always_ff @(posedge clk)
    if (!rst) begin
      vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  // Line storage needs no reset; slots are only read while marked valid
  always_ff @(posedge clk)
    if (push) begin
      tag_q[wr_ptr] <= req_addr[PADDR-1:OFF];
      line_q[wr_ptr] <= req_data;
    end
  // Beat index into the head line; wraps to 0 after the last beat
  always_ff @(posedge clk)
    if (!rst) beat <= '0;
    else if (w_hs) beat <= beat + 1'b1;
`ifdef AXI_WB_AW_W_PARALLEL_EN
  localparam logic [1:0] IDLE = 2'd0, AWW = 2'd1, B = 2'd3;
  logic aw_done, w_done, go_b;
  assign go_b = (aw_done || aw_hs) && (w_done || w_end);
  // Address and data issued together; B entered once both channels are finished
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state == IDLE ? (count != '0 ? AWW : IDLE) : state == AWW ? (go_b ? B : AWW) : (pop ? IDLE : B);
      aw_done <= state == AWW && !go_b && (aw_done || aw_hs);
      w_done <= state == AWW && !go_b && (w_done || w_end);
    end
  assign aw_valid = state == AWW && !aw_done;
  assign w_valid = state == AWW && !w_done;
`else
  localparam logic [1:0] IDLE = 2'd0, AW = 2'd1, W = 2'd2, B = 2'd3;
  // Strict address phase, then data burst, then wait for the write response
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state == IDLE ? (count != '0 ? AW : IDLE) : state == AW ? (aw_hs ? W : AW) : state == W ? (w_end ? B : W) : (pop ? IDLE : B);
  assign aw_valid = state == AW;
  assign w_valid = state == W;
`endif
  // Channel payloads come from the head slot and are zero whenever not valid
  always_comb begin
    axi.maw = '0;
    axi.mw = '0;
    axi.mb = '0;
    axi.mar = '0;
    axi.mr = '0;
    axi.maw.valid = aw_valid;
    axi.mw.valid = w_valid;
    axi.mb.ready = state == B;
    if (aw_valid) begin
      axi.maw.id = WB_ID;
      axi.maw.addr = PADDR_BUS'({tag_q[rd_ptr], {OFF{1'b0}}});
      axi.maw.len = 8'(LINE_BEATS - 1);
      axi.maw.size = 3'($clog2(XLEN / 8));
      axi.maw.burst = 2'b01;
      axi.maw.cache = 4'b0011;
    end
    if (w_valid) begin
      axi.mw.data = line_q[rd_ptr][beat*XLEN +: XLEN];
      axi.mw.strb = '1;
      axi.mw.last = beat == BW'(LINE_BEATS - 1);
    end
  end
endmodule

// File: tb/tb_axi_wb_writer.sv
// tb_axi_wb_writer: randomized scoreboard bench for the write-back buffer
module tb_axi_wb_writer;
  import axi_wb_pkg::*;
  localparam int DEPTH = 2;
  localparam int LB = 8;
  localparam int LW = LB * XLEN;
  localparam int OFF = $clog2(LW / 8);
`ifdef AXI_WB_AW_W_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic [PADDR_BUS-1:0] req_addr = '0;
  logic [PADDR_BUS-1:0] query_addr = '0;
  logic [LW-1:0] req_data = '0;
  logic req_ready, query_hit, wb_err;
  AxiIO axi ();
  axi_wb_writer #(.DEPTH(DEPTH), .LINE_BEATS(LB), .WB_ID(4'h1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .query_addr(query_addr),
    .query_hit(query_hit), .wb_err(wb_err), .axi(axi)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [PADDR-OFF-1:0] lines[$];
  ax_t exp_aw[$];
  w_t exp_w[$];
  int aw_seen = 0, wl_seen = 0, b_issued = 0, b_done = 0;
  bit b_fired = 0, flush = 0;
  int aw_mode = 1, w_mode = 1, b_mode = 1, err_mode = 0;
  int err_pulses = 0, wbeat = 0, wpat = 0;
  ax_t prev_aw = '0;
  w_t prev_w = '0;
  bit prev_aw_stall = 0, prev_w_stall = 0, prev_awv = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction
  // Monitor: compare every cycle against the queue model, then advance the model
  always @(negedge clk) begin : mon
    logic exp_ready, exp_hit, exp_mbr, bhs, awhs, whs;
    ax_t ea;
    w_t ew;
    exp_ready = lines.size() < DEPTH;
    exp_hit = 1'b0;
    foreach (lines[i]) if (lines[i] == query_addr[PADDR-1:OFF]) exp_hit = 1'b1;
    exp_mbr = mn(aw_seen, wl_seen) > b_done;
    chk("req_ready", req_ready, exp_ready);
    chk("query_hit", query_hit, exp_hit);
    chk("b_ready", axi.mb.ready, exp_mbr);
    bhs = axi.sb.valid && exp_mbr;
    chk("wb_err", wb_err, bhs && axi.sb.resp != 2'b00);
    if (wb_err) err_pulses++;
    chk("rd_tie", {axi.mar, axi.mr}, '0);
    if (prev_aw_stall) chk("aw_stable", axi.maw, prev_aw);
    if (prev_w_stall) chk("w_stable", axi.mw, prev_w);
    if (axi.maw.valid && !prev_awv) chk("aw_w_together", axi.mw.valid, PAR);
    awhs = axi.maw.valid && axi.saw.ready;
    whs = axi.mw.valid && axi.sw.ready;
    if (awhs) begin
      if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
      else chk("aw", axi.maw, exp_aw.pop_front());
      aw_seen++;
    end
    if (whs) begin
      if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
      else begin
        ew = exp_w.pop_front();
        chk("w", axi.mw, ew);
        if (ew.last) wl_seen++;
        wbeat = ew.last ? 0 : wbeat + 1;
      end
    end
    if (bhs) begin
      b_done++;
      b_fired = 1;
      if (lines.size() > 0) void'(lines.pop_front());
    end
    if (req_valid && exp_ready) begin
      ea = '0;
      ea.valid = 1'b1;
      ea.id = 4'h1;
      ea.addr = req_addr & ~PADDR_BUS'(LW / 8 - 1);
      ea.len = 8'(LB - 1);
      ea.size = 3'($clog2(XLEN / 8));
      ea.burst = 2'b01;
      ea.cache = 4'b0011;
      exp_aw.push_back(ea);
      for (int i = 0; i < LB; i++) begin
        ew = '0;
        ew.valid = 1'b1;
        ew.data = req_data[i*XLEN +: XLEN];
        ew.strb = '1;
        ew.last = i == LB - 1;
        exp_w.push_back(ew);
      end
      lines.push_back(req_addr[PADDR-1:OFF]);
    end
    prev_aw = axi.maw;
    prev_w = axi.mw;
    prev_aw_stall = axi.maw.valid && !axi.saw.ready && rst;
    prev_w_stall = axi.mw.valid && !axi.sw.ready && rst;
    prev_awv = axi.maw.valid && rst;
    if (!rst) begin
      lines.delete();
      exp_aw.delete();
      exp_w.delete();
      aw_seen = 0;
      wl_seen = 0;
      b_done = 0;
      wbeat = 0;
      flush = 1;
    end
  end
  // Slave model: ready patterns and B responses, driven just after each rising edge
  initial begin
    axi.saw = '0;
    axi.sw = '0;
    axi.sb = '0;
    axi.sar = '0;
    axi.sr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (flush) begin
        axi.sb = '0;
        flush = 0;
        b_fired = 0;
        b_issued = 0;
      end
      if (b_fired) begin
        axi.sb.valid = 1'b0;
        b_fired = 0;
      end
      axi.saw.ready = aw_mode == 1 ? 1'b1 : aw_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      axi.sw.ready = w_mode == 1 ? 1'b1 : w_mode == 3 ? (wpat % 4 == 0 || wpat % 4 == 3) : 1'($urandom_range(0, 1));
      wpat++;
      if (!axi.sb.valid && mn(aw_seen, wl_seen) > b_issued && (b_mode == 1 || $urandom_range(0, 2) == 0)) begin
        axi.sb.valid = 1'b1;
        axi.sb.id = 4'h1;
        axi.sb.resp = err_mode == 1 ? 2'b10 : err_mode == 2 ? 2'($urandom_range(0, 3)) : 2'b00;
        if (err_mode == 1) err_mode = 0;
        b_issued++;
      end
    end
  end
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  function automatic logic [PADDR_BUS-1:0] rand_addr();
    return 32'h8000_0000 | PADDR_BUS'($urandom_range(0, 7) << 6) | PADDR_BUS'($urandom_range(0, 63));
  endfunction
  task automatic push_line(input logic [PADDR_BUS-1:0] a, input logic [LW-1:0] d);
    bit ok = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = req_ready;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("push_wait", ok, 1'b1);
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      #1;
      ok = lines.size() == 0 && exp_aw.size() == 0 && !axi.sb.valid;
    end
    chk("idle_wait", ok, 1'b1);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    query_addr = 32'h8000_0040;
    push_line(32'h8000_0044, rand_line());
    @(negedge clk);
    chk("aw_lat_n1", axi.maw.valid, 1'b0);
    @(negedge clk);
    chk("aw_lat_n2", axi.maw.valid, 1'b1);
    wait_idle();
    aw_mode = 2;
    fork
      for (int k = 0; k < 3; k++) push_line(rand_addr(), rand_line());
      begin
        repeat (30) @(posedge clk);
        #1 aw_mode = 1;
      end
    join
    wait_idle();
    w_mode = 3;
    push_line(32'h8000_0040, rand_line());
    wait_idle();
    w_mode = 1;
    err_mode = 1;
    err_pulses = 0;
    push_line(rand_addr(), rand_line());
    push_line(rand_addr(), rand_line());
    wait_idle();
    chk("err_pulses", err_pulses, 1);
    aw_mode = 0;
    w_mode = 0;
    b_mode = 0;
    err_mode = 2;
    for (int k = 0; k < 40; k++) begin
      query_addr = rand_addr();
      push_line(rand_addr(), rand_line());
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();
    err_mode = 0;
    aw_mode = 1;
    w_mode = 1;
    b_mode = 1;
    push_line(32'h8000_0080, rand_line());
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clk);
      ok = wbeat == 3;
    end
    chk("reach_beat3", ok, 1'b1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_awvalid", axi.maw.valid, 1'b0);
    chk("rst_wvalid", axi.mw.valid, 1'b0);
    chk("rst_bready", axi.mb.ready, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    push_line(32'h8000_0044, rand_line());
    wait_idle();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
